// File: rtl/cpu_pkg.sv
// Shared types and constants for the Hack-style CPU front end.
// Holds the fetch FSM state type, default widths and jump-bit positions.
package cpu_pkg;

   localparam int DW_DEF = 16;
   localparam int AW_DEF = 15;

   // Bit positions of the jump field inside a C-instruction (lt, eq, gt)
   localparam int J1 = 2;
   localparam int J2 = 1;
   localparam int J3 = 0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      VALID = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/jump_unit.sv
// Combinational branch decision from the jump bits and ALU flags.
// A-instructions never branch regardless of what the j-bits read.
module jump_unit
   import cpu_pkg::*;
(
   input  logic       instr_type,
   input  logic [2:0] jbits,
   input  logic       alu_zr,
   input  logic       alu_ng,
   output logic       taken
);

   logic pos;

   assign pos   = !alu_ng && !alu_zr;
   assign taken = instr_type && ((jbits[J1] && alu_ng) ||
                                 (jbits[J2] && alu_zr) ||
                                 (jbits[J3] && pos));

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, fetches from ROM over req/ack and holds one
// instruction until the execute stage retires it, then steps or branches.
module instr_fetch
   import cpu_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int AW = AW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   output logic [AW-1:0] rom_addr,
   output logic          rom_req,
   input  logic          rom_ack,
   input  logic [DW-1:0] rom_data,
   output logic [DW-1:0] instr,
   output logic          instr_valid,
   input  logic          instr_ready,
   input  logic          instr_type,
   input  logic          cmd_j1,
   input  logic          cmd_j2,
   input  logic          cmd_j3,
   input  logic          alu_zr,
   input  logic          alu_ng,
   input  logic [AW-1:0] a_reg,
   output logic [AW-1:0] pc
);

   fetch_state_t state, state_nxt;
   logic         taken;
   logic         retire;
   logic         fetch_done;

   jump_unit u_jump (
      .instr_type (instr_type),
      .jbits      ({cmd_j1, cmd_j2, cmd_j3}),
      .alu_zr     (alu_zr),
      .alu_ng     (alu_ng),
      .taken      (taken)
   );

   assign rom_req    = (state == FETCH);
   assign rom_addr   = pc;
   assign fetch_done = (state == FETCH) && rom_ack;
   assign retire     = (state == VALID) && instr_ready;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = FETCH;
         FETCH:   if (rom_ack) state_nxt = VALID;
         VALID:   if (instr_ready) state_nxt = FETCH;
         default: state_nxt = IDLE;
      endcase
   end

   // Jump inputs are only trusted in the retire cycle, so the branch
   // decision is consumed exactly there and nowhere else.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         pc          <= '0;
         instr       <= '0;
         instr_valid <= 1'b0;
      end else begin
         state <= state_nxt;
         if (fetch_done) begin
            instr       <= rom_data;
            instr_valid <= 1'b1;
         end
         if (retire) begin
            pc          <= taken ? a_reg : pc + 1'b1;
            instr_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized and directed bench for instr_fetch against a transaction-level
// model: each instruction is fetched, held, retired and the next PC predicted.
module tb_instr_fetch;

   localparam int DW = 16;
   localparam int AW = 15;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] rom_addr;
   logic          rom_req;
   logic          rom_ack;
   logic [DW-1:0] rom_data;
   logic [DW-1:0] instr;
   logic          instr_valid;
   logic          instr_ready;
   logic          instr_type;
   logic          cmd_j1, cmd_j2, cmd_j3;
   logic          alu_zr, alu_ng;
   logic [AW-1:0] a_reg;
   logic [AW-1:0] pc;

   int n_checks = 0;
   int n_pass   = 0;
   logic [AW-1:0] exp_pc;

   instr_fetch #(.DW(DW), .AW(AW)) dut (
      .clk         (clk),
      .rst         (rst),
      .rom_addr    (rom_addr),
      .rom_req     (rom_req),
      .rom_ack     (rom_ack),
      .rom_data    (rom_data),
      .instr       (instr),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr_type  (instr_type),
      .cmd_j1      (cmd_j1),
      .cmd_j2      (cmd_j2),
      .cmd_j3      (cmd_j3),
      .alu_zr      (alu_zr),
      .alu_ng      (alu_ng),
      .a_reg       (a_reg),
      .pc          (pc)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs === exp_v) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Jump-side inputs are don't-care outside the retire cycle; scramble them.
   task automatic junk();
      instr_type = 1'($urandom);
      {cmd_j1, cmd_j2, cmd_j3} = 3'($urandom);
      {alu_zr, alu_ng} = 2'($urandom);
      a_reg    = AW'($urandom);
      rom_data = DW'($urandom);
   endtask

   // Hack jump semantics on a signed ALU result value.
   function automatic logic [AW-1:0] predict(input logic [DW-1:0] w, input int r,
                                             input logic [AW-1:0] tgt, input logic [AW-1:0] cur);
      bit jump;
      jump = w[15] && ((w[2] && r < 0) || (w[1] && r == 0) || (w[0] && r > 0));
      return jump ? tgt : AW'((int'(cur) + 1) % (1 << AW));
   endfunction

   // One full instruction: entered in the first FETCH cycle, leaves in the
   // first FETCH cycle of the next instruction.
   task automatic do_instr(input int waits, input int stalls, input logic [DW-1:0] w,
                           input int r, input logic [AW-1:0] tgt);
      chk("fetch_req", 32'(rom_req), 32'd1);
      chk("fetch_addr", 32'(rom_addr), 32'(exp_pc));
      chk("fetch_nvalid", 32'(instr_valid), 32'd0);
      for (int i = 0; i < waits; i++) begin
         rom_ack = 1'b0;
         junk();
         step();
         chk("wait_req", 32'(rom_req), 32'd1);
         chk("wait_addr", 32'(rom_addr), 32'(exp_pc));
         chk("wait_nvalid", 32'(instr_valid), 32'd0);
      end
      rom_ack  = 1'b1;
      rom_data = w;
      step();
      rom_ack = 1'b0;
      junk();
      chk("valid", 32'(instr_valid), 32'd1);
      chk("instr", 32'(instr), 32'(w));
      chk("valid_nreq", 32'(rom_req), 32'd0);
      for (int i = 0; i < stalls; i++) begin
         instr_ready = 1'b0;
         rom_ack = 1'($urandom);
         junk();
         step();
         chk("stall_instr", 32'(instr), 32'(w));
         chk("stall_valid", 32'(instr_valid), 32'd1);
         chk("stall_pc", 32'(pc), 32'(exp_pc));
         chk("stall_nreq", 32'(rom_req), 32'd0);
      end
      rom_ack     = 1'b0;
      instr_ready = 1'b1;
      instr_type  = w[15];
      {cmd_j1, cmd_j2, cmd_j3} = w[2:0];
      alu_zr = (r == 0);
      alu_ng = (r < 0);
      a_reg  = tgt;
      step();
      instr_ready = 1'b0;
      junk();
      exp_pc = predict(w, r, tgt, exp_pc);
      chk("retire_pc", 32'(pc), 32'(exp_pc));
      chk("retire_nvalid", 32'(instr_valid), 32'd0);
   endtask

   initial begin
      int r;
      rst = 1'b1;
      rom_ack = 1'b0;
      instr_ready = 1'b0;
      junk();
      step();
      step();
      chk("rst_req", 32'(rom_req), 32'd0);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_pc", 32'(pc), 32'd0);
      chk("rst_addr", 32'(rom_addr), 32'd0);
      chk("rst_instr", 32'(instr), 32'd0);
      exp_pc = '0;

      rst = 1'b0;
      chk("idle_nreq", 32'(rom_req), 32'd0);
      step();

      // Zero-wait sequential fetch with data equal to address (A-instructions)
      for (int a = 0; a < 5; a++) do_instr(0, 0, DW'(a), 0, AW'($urandom));
      // Three ROM wait cycles at address 5
      do_instr(3, 0, 16'h0005, 0, AW'($urandom));
      // Four stall cycles on a non-jumping C-instruction
      do_instr(0, 4, 16'hEC10, 1, AW'($urandom));
      // JEQ taken then not taken
      do_instr(0, 0, 16'hE302, 0, 15'h0123);
      do_instr(0, 0, 16'hE302, 5, 15'h0456);
      // Jump to the top of memory, JMP out, then come back and wrap
      do_instr(0, 0, 16'hEA87, 3, 15'h7FFF);
      chk("at_top", 32'(pc), 32'h7FFF);
      do_instr(1, 1, 16'hEA87, 7, 15'h0010);
      chk("jmp_top", 32'(pc), 32'h0010);
      do_instr(0, 0, 16'hEA87, -2, 15'h7FFF);
      do_instr(0, 0, 16'h7FFF, -1, 15'h1234);
      chk("wrap", 32'(pc), 32'h0000);

      // Randomized traffic
      for (int t = 0; t < 60; t++) begin
         r = ($urandom_range(0, 3) == 0) ? 0 : int'($signed(16'($urandom)));
         do_instr(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                  DW'($urandom), r, AW'($urandom));
      end

      // Reset while a fetch is outstanding with ack pending; late ack ignored
      chk("pre_rst_req", 32'(rom_req), 32'd1);
      rst = 1'b1;
      rom_ack = 1'b1;
      rom_data = 16'hBEEF;
      step();
      chk("mid_rst_req", 32'(rom_req), 32'd0);
      chk("mid_rst_valid", 32'(instr_valid), 32'd0);
      chk("mid_rst_pc", 32'(pc), 32'd0);
      rst = 1'b0;
      step();
      rom_ack = 1'b0;
      chk("late_ack_nvalid", 32'(instr_valid), 32'd0);
      exp_pc = '0;
      do_instr(0, 0, 16'h0042, 0, AW'($urandom));
      do_instr(2, 0, 16'hE307, 9, 15'h0ABC);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
